set_assoc_cache: RTL

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/set_assoc_cache_if.sv | 25 ++
 rtl/set_assoc_cache.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache_if.sv
// Wishbone-style bus bundle used on both sides of set_assoc_cache.
// primary drives cyc/stb/we/sel/addr/dat_o_p; secondary returns dat_i_p/ack.
interface wishbone_if #(
    parameter int ADDR_SIZE = 15,
    parameter int DATA_SIZE = 32
);
    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [DATA_SIZE/8-1:0] sel;
    logic [ADDR_SIZE-1:0]   addr;
    logic [DATA_SIZE-1:0]   dat_o_p;
    logic [DATA_SIZE-1:0]   dat_i_p;
    logic                   ack;

    modport primary (
        output cyc, stb, we, sel, addr, dat_o_p,
        input  dat_i_p, ack
    );

    modport secondary (
        input  cyc, stb, we, sel, addr, dat_o_p,
        output dat_i_p, ack
    );
endinterface

// File: rtl/set_assoc_cache.sv
// Write-back set-associative cache, round-robin replacement per set.
// Ports: clock, reset (async, active high); wb_if_ctrl (processor side,
// DATA_SIZE words); wb_if_mem (memory side, BLOCK_SIZE lines).
// Optional SET_ASSOC_CACHE_PERF_CNT_EN adds hit_count/miss_count outputs.
module set_assoc_cache #(
    parameter int CACHE_SIZE = 4096,
    parameter int BLOCK_SIZE = 128,
    parameter int ADDR_SIZE  = 15,
    parameter int DATA_SIZE  = 32,
    parameter int WAYS       = 2
) (
    input  logic          clock,
    input  logic          reset,
    wishbone_if.secondary wb_if_ctrl,
    wishbone_if.primary   wb_if_mem
`ifdef SET_ASSOC_CACHE_PERF_CNT_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);
    localparam int OFF_W  = $clog2(BLOCK_SIZE / 8);
    localparam int SETS   = CACHE_SIZE * 8 / (BLOCK_SIZE * WAYS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_SIZE - OFF_W - IDX_W;
    localparam int WOFF_W = $clog2(DATA_SIZE / 8);
    localparam int WSEL_W = OFF_W - WOFF_W;
    localparam int NB     = DATA_SIZE / 8;
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOOKUP    = 3'd1;
    localparam logic [2:0] WRITEBACK = 3'd2;
    localparam logic [2:0] REFILL    = 3'd3;
    localparam logic [2:0] RESPOND   = 3'd4;

    logic [2:0]            state;
    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WSEL_W-1:0]     req_word;
    logic                  req_we;
    logic [NB-1:0]         req_sel;
    logic [DATA_SIZE-1:0]  req_dat;
    logic [PTR_W-1:0]      victim;
    logic                  retry;
    logic [DATA_SIZE-1:0]  rdata;

    logic [WAYS-1:0]       valid [SETS];
    logic [WAYS-1:0]       dirty [SETS];
    logic [PTR_W-1:0]      ptr   [SETS];
    logic [TAG_W-1:0]      tags  [SETS][WAYS];
    logic [BLOCK_SIZE-1:0] lines [SETS][WAYS];

    logic                  hit;
    logic                  has_inv;
    logic [PTR_W-1:0]      hit_way;
    logic [PTR_W-1:0]      inv_way;
    logic [PTR_W-1:0]      miss_way;
    logic [BLOCK_SIZE-1:0] hit_line;
    logic [DATA_SIZE-1:0]  hit_word;
    logic [DATA_SIZE-1:0]  merged;

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = PTR_W'(w);
            end
            if (!valid[req_idx][w]) begin
                has_inv = 1'b1;
                inv_way = PTR_W'(w);
            end
        end
    end

    assign miss_way = has_inv ? inv_way : ptr[req_idx];
    assign hit_line = lines[req_idx][hit_way];
    assign hit_word = hit_line[int'(req_word) * DATA_SIZE +: DATA_SIZE];

    always_comb begin
        merged = hit_word;
        for (int b = 0; b < NB; b++) begin
            if (req_sel[b]) merged[b*8 +: 8] = req_dat[b*8 +: 8];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            req_tag  <= '0;
            req_idx  <= '0;
            req_word <= '0;
            req_we   <= 1'b0;
            req_sel  <= '0;
            req_dat  <= '0;
            victim   <= '0;
            retry    <= 1'b0;
            rdata    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                ptr[s]   <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (wb_if_ctrl.cyc && wb_if_ctrl.stb) begin
                        req_tag  <= wb_if_ctrl.addr[ADDR_SIZE-1 -: TAG_W];
                        req_idx  <= wb_if_ctrl.addr[OFF_W +: IDX_W];
                        req_word <= wb_if_ctrl.addr[WOFF_W +: WSEL_W];
                        req_we   <= wb_if_ctrl.we;
                        // An all-zero byte mask means a full-word write.
                        req_sel  <= (wb_if_ctrl.sel == '0) ? '1 : wb_if_ctrl.sel;
                        req_dat  <= wb_if_ctrl.dat_o_p;
                        retry    <= 1'b0;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        rdata <= req_we ? merged : hit_word;
                        if (req_we) dirty[req_idx][hit_way] <= 1'b1;
                        state <= RESPOND;
                    end else begin
                        victim <= miss_way;
                        if (valid[req_idx][miss_way] && dirty[req_idx][miss_way])
                            state <= WRITEBACK;
                        else
                            state <= REFILL;
                    end
                end
                WRITEBACK: begin
                    if (wb_if_mem.ack) begin
                        dirty[req_idx][victim] <= 1'b0;
                        state <= REFILL;
                    end
                end
                REFILL: begin
                    if (wb_if_mem.ack) begin
                        valid[req_idx][victim] <= 1'b1;
                        dirty[req_idx][victim] <= 1'b0;
                        ptr[req_idx] <= (WAYS == 1) ? '0 : ptr[req_idx] + 1'b1;
                        retry <= 1'b1;
                        state <= LOOKUP;
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage needs no reset: valid bits gate every use.
    always_ff @(posedge clock) begin
        if (state == LOOKUP && hit && req_we)
            lines[req_idx][hit_way][int'(req_word) * DATA_SIZE +: DATA_SIZE] <= merged;
        if (state == REFILL && wb_if_mem.ack) begin
            lines[req_idx][victim] <= wb_if_mem.dat_i_p;
            tags[req_idx][victim]  <= req_tag;
        end
    end

    // Memory bus is decoded straight from state so reset drops it at once.
    logic mem_busy;
    assign mem_busy          = (state == WRITEBACK) || (state == REFILL);
    assign wb_if_mem.cyc     = mem_busy;
    assign wb_if_mem.stb     = mem_busy;
    assign wb_if_mem.we      = (state == WRITEBACK);
    assign wb_if_mem.sel     = '1;
    assign wb_if_mem.addr    = {(state == WRITEBACK) ? tags[req_idx][victim] : req_tag,
                                req_idx, {OFF_W{1'b0}}};
    assign wb_if_mem.dat_o_p = lines[req_idx][victim];

    assign wb_if_ctrl.ack     = (state == RESPOND);
    assign wb_if_ctrl.dat_i_p = rdata;

`ifdef SET_ASSOC_CACHE_PERF_CNT_EN
    // Only the first lookup of a request counts; the post-refill retry does not.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP && !retry) begin
            if (hit && hit_count != '1) hit_count <= hit_count + 32'd1;
            if (!hit && miss_count != '1) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule
